sound_tune_player: RTL and testbench

Tick-driven tune sequencer for the game sound path. Consumes the single-cycle `tick` pulse from the sound tick counter and steps through one of four fixed melodies held in an internal ROM. For each note it holds a 4-bit tone index for that note's duration in ticks, then raises a one-cycle `done` pulse when the melody ends. It sits between game-event logic (which issues `start`/`stop`) and the tone-frequency generator (which consumes `tone`/`sound_on`).

---
 rtl/sound_tune_player.sv | 153 +++++++++++++++
 tb/tb_sound_tune_player.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_tune_player.sv
// ============================================================================
// sound_tune_player : steps through one of four ROM melodies on tick pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module sound_tune_player #(
  parameter int TUNE_LEN = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] tune_sel,
  output logic [3:0] tone,
  output logic       sound_on,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST_IDX = 3'(TUNE_LEN - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [1:0] sel_q;
  logic [2:0] rem_q;
  logic [3:0] tone_q;
  logic       sound_on_q;
  logic       busy_q;
  logic       done_q;

  logic [6:0] start_entry_d;
  logic [6:0] next_entry_d;
  logic [2:0] next_idx_d;

  // Entry layout is {note[3:0], dur[2:0]}; dur of 0 terminates the tune.
  function automatic logic [6:0] rom_entry(input logic [1:0] s, input logic [2:0] i);
    logic [6:0] e;
    e = 7'd0;
    case (s)
      2'd0: begin
        case (i)
          3'd0:    e = {4'd5, 3'd1};
          3'd1:    e = {4'd9, 3'd1};
          default: e = 7'd0;
        endcase
      end
      2'd1: begin
        case (i)
          3'd0:    e = {4'd12, 3'd2};
          3'd1:    e = {4'd10, 3'd2};
          3'd2:    e = {4'd8,  3'd2};
          3'd3:    e = {4'd5,  3'd3};
          default: e = 7'd0;
        endcase
      end
      2'd2: begin
        case (i)
          3'd0:    e = {4'd1, 3'd1};
          3'd1:    e = {4'd3, 3'd1};
          3'd2:    e = {4'd5, 3'd1};
          3'd3:    e = {4'd8, 3'd2};
          3'd4:    e = {4'd5, 3'd1};
          3'd5:    e = {4'd8, 3'd4};
          default: e = 7'd0;
        endcase
      end
      default: e = i[0] ? {4'd0, 3'd1} : {4'd15, 3'd1};
    endcase
    return e;
  endfunction

  always_comb begin
    next_idx_d    = idx_q + 3'd1;
    start_entry_d = rom_entry(tune_sel, 3'd0);
    next_entry_d  = rom_entry(sel_q, next_idx_d);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      sel_q      <= 2'd0;
      rem_q      <= 3'd0;
      tone_q     <= 4'd0;
      sound_on_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == PLAY && stop) begin
        state_q    <= IDLE;
        idx_q      <= 3'd0;
        rem_q      <= 3'd0;
        tone_q     <= 4'd0;
        sound_on_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
      end else if (start) begin
        // Same load path whether idle or restarting mid-tune.
        sel_q <= tune_sel;
        idx_q <= 3'd0;
        if (start_entry_d[2:0] != 3'd0) begin
          state_q    <= PLAY;
          rem_q      <= start_entry_d[2:0];
          tone_q     <= start_entry_d[6:3];
          sound_on_q <= (start_entry_d[6:3] != 4'd0);
          busy_q     <= 1'b1;
        end else begin
          state_q    <= IDLE;
          rem_q      <= 3'd0;
          tone_q     <= 4'd0;
          sound_on_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
      end else if (state_q == PLAY && tick) begin
        if (rem_q == 3'd1) begin
          if (idx_q == c_LAST_IDX || next_entry_d[2:0] == 3'd0) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            rem_q      <= 3'd0;
            tone_q     <= 4'd0;
            sound_on_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            idx_q      <= next_idx_d;
            rem_q      <= next_entry_d[2:0];
            tone_q     <= next_entry_d[6:3];
            sound_on_q <= (next_entry_d[6:3] != 4'd0);
          end
        end else begin
          rem_q <= rem_q - 3'd1;
        end
      end
    end
  end

  assign tone     = tone_q;
  assign sound_on = sound_on_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_tune_player.sv
// ============================================================================
// tb_sound_tune_player : directed self-checking bench for sound_tune_player
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sound_tune_player;

  logic       clk;
  logic       resetN;
  logic       tick;
  logic       start;
  logic       stop;
  logic [1:0] tune_sel;
  logic [3:0] tone;
  logic       sound_on;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  sound_tune_player #(.TUNE_LEN(8)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .tune_sel (tune_sel),
    .tone     (tone),
    .sound_on (sound_on),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set before the call are sampled on that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sel, input logic with_tick);
    start = 1'b1; tune_sel = sel; tick = with_tick;
    step();
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({tone, sound_on, busy, done} !== 7'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {tone, sound_on, busy, done}, 7'h00);
    end
  endtask

  task automatic test_tune0();
    do_start(2'd0, 1'b0);
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd5, 3'b110}) begin
      failures++;
      $display("FAIL t0_first got=%h exp=%h", {tone, sound_on, busy, done}, {4'd5, 3'b110});
    end
    repeat (3) step();
    checks++;
    if (tone !== 4'd5) begin
      failures++;
      $display("FAIL t0_hold tone=%0d exp=5", tone);
    end
    do_tick();
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd9, 3'b110}) begin
      failures++;
      $display("FAIL t0_second got=%h exp=%h", {tone, sound_on, busy, done}, {4'd9, 3'b110});
    end
    repeat (3) step();
    do_tick();
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd0, 3'b001}) begin
      failures++;
      $display("FAIL t0_end got=%h exp=%h", {tone, sound_on, busy, done}, {4'd0, 3'b001});
    end
    // Start accepted in the very cycle done is high.
    do_start(2'd1, 1'b0);
    checks++;
    if ({tone, busy, done} !== {4'd12, 2'b10}) begin
      failures++;
      $display("FAIL t0_start_on_done got=%h exp=%h", {tone, busy, done}, {4'd12, 2'b10});
    end
    stop = 1'b1; step(); stop = 1'b0;
    step();
  endtask

  task automatic test_tune1();
    logic [3:0] exp_tone [9];
    exp_tone = '{4'd12, 4'd12, 4'd10, 4'd10, 4'd8, 4'd8, 4'd5, 4'd5, 4'd5};
    do_start(2'd1, 1'b1);
    checks++;
    if ({tone, sound_on, busy} !== {exp_tone[0], 2'b11}) begin
      failures++;
      $display("FAIL t1_first got=%h exp=%h", {tone, sound_on, busy}, {exp_tone[0], 2'b11});
    end
    for (int i = 1; i < 9; i++) begin
      do_tick();
      checks++;
      if ({tone, sound_on, busy, done} !== {exp_tone[i], 3'b110}) begin
        failures++;
        $display("FAIL t1_seq[%0d] got=%h exp=%h", i, {tone, sound_on, busy, done}, {exp_tone[i], 3'b110});
      end
    end
    do_tick();
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd0, 3'b001}) begin
      failures++;
      $display("FAIL t1_end got=%h exp=%h", {tone, sound_on, busy, done}, {4'd0, 3'b001});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL t1_done_width done=%b exp=0", done);
    end
  endtask

  task automatic test_tune3();
    logic [3:0] exp_t;
    do_start(2'd3, 1'b0);
    checks++;
    if ({tone, sound_on, busy} !== {4'd15, 2'b11}) begin
      failures++;
      $display("FAIL t3_first got=%h exp=%h", {tone, sound_on, busy}, {4'd15, 2'b11});
    end
    for (int k = 1; k < 8; k++) begin
      step();
      do_tick();
      exp_t = (k % 2 == 0) ? 4'd15 : 4'd0;
      checks++;
      if ({tone, sound_on, busy, done} !== {exp_t, exp_t != 4'd0, 2'b10}) begin
        failures++;
        $display("FAIL t3_seq[%0d] got=%h exp=%h", k, {tone, sound_on, busy, done}, {exp_t, exp_t != 4'd0, 2'b10});
      end
    end
    step();
    do_tick();
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd0, 3'b001}) begin
      failures++;
      $display("FAIL t3_end got=%h exp=%h", {tone, sound_on, busy, done}, {4'd0, 3'b001});
    end
    repeat (3) do_tick();
    checks++;
    if ({tone, busy, done} !== {4'd0, 2'b00}) begin
      failures++;
      $display("FAIL t3_no_replay got=%h exp=%h", {tone, busy, done}, {4'd0, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    do_start(2'd2, 1'b0);
    do_tick();
    do_tick();
    checks++;
    if (tone !== 4'd5) begin
      failures++;
      $display("FAIL b2b_third_note tone=%0d exp=5", tone);
    end
    // Restart with a coincident tick; the tick must be ignored.
    do_start(2'd0, 1'b1);
    checks++;
    if ({tone, busy, done} !== {4'd5, 2'b10}) begin
      failures++;
      $display("FAIL b2b_restart got=%h exp=%h", {tone, busy, done}, {4'd5, 2'b10});
    end
    do_tick();
    checks++;
    if ({tone, busy, done} !== {4'd9, 2'b10}) begin
      failures++;
      $display("FAIL b2b_t0_second got=%h exp=%h", {tone, busy, done}, {4'd9, 2'b10});
    end
    do_tick();
    checks++;
    if ({tone, busy, done} !== {4'd0, 2'b01}) begin
      failures++;
      $display("FAIL b2b_t0_end got=%h exp=%h", {tone, busy, done}, {4'd0, 2'b01});
    end
    step();
  endtask

  task automatic test_stop();
    do_start(2'd1, 1'b0);
    do_tick();
    stop = 1'b1; start = 1'b1; tune_sel = 2'd0; tick = 1'b1;
    step();
    stop = 1'b0; start = 1'b0; tick = 1'b0;
    checks++;
    if ({tone, sound_on, busy, done} !== {4'd0, 3'b001}) begin
      failures++;
      $display("FAIL stop_abort got=%h exp=%h", {tone, sound_on, busy, done}, {4'd0, 3'b001});
    end
    step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL stop_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_reset_mid();
    do_start(2'd2, 1'b0);
    do_tick();
    tick = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if ({tone, sound_on, busy, done} !== 7'h00) begin
      failures++;
      $display("FAIL rst_async got=%h exp=%h", {tone, sound_on, busy, done}, 7'h00);
    end
    step();
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({tone, busy, done} !== 6'h00) begin
        failures++;
        $display("FAIL rst_quiet[%0d] got=%h exp=00", i, {tone, busy, done});
      end
    end
    tick = 1'b0;
    do_start(2'd0, 1'b0);
    checks++;
    if ({tone, busy} !== {4'd5, 1'b1}) begin
      failures++;
      $display("FAIL rst_restart got=%h exp=%h", {tone, busy}, {4'd5, 1'b1});
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    resetN = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; tune_sel = 2'd0;
    repeat (3) step();
    resetN = 1'b1;
    step();
    test_reset();
    test_tune0();
    test_tune1();
    test_tune3();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
